dat_mem_stk: RTL and testbench

Parametrised successor to the processor's byte data memory. A single-clock memory array serves ordinary loads and stores through a random-access port. A hardware stack region at the top of the array serves push/pop operations with an internal depth counter, full/empty status and sticky error flags. It sits in the datapath in place of the plain data memory, so the core can implement calls, returns and spills without maintaining a software stack pointer.

---
 rtl/dat_mem_pkg.sv | 34 +++
 rtl/dat_mem_stk_stk_ctrl.sv | 67 ++++++
 rtl/dat_mem_stk.sv | 134 +++++++++++++
 tb/tb_dat_mem_stk.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dat_mem_pkg.sv
// Shared types, defaults and the stack-operation decoder for dat_mem_stk.
// Latency: none; the package holds declarations and combinational helpers only.
// Backpressure: none; the decoder turns requests that cannot be honoured into STK_NOP.
package dat_mem_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 8;

    typedef enum logic [1:0] {
        STK_NOP  = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2,
        STK_SWAP = 2'd3
    } stk_op_t;

    // Effective stack operation for one cycle. A push/pop pair on an empty
    // stack has nothing to pop, so it behaves as a plain push.
    function automatic stk_op_t stk_decode(input logic push,
                                           input logic pop,
                                           input logic full,
                                           input logic empty);
        stk_op_t op;
        op = STK_NOP;
        if (push && pop) begin
            op = empty ? STK_PUSH : STK_SWAP;
        end else if (push) begin
            op = full ? STK_NOP : STK_PUSH;
        end else if (pop) begin
            op = empty ? STK_NOP : STK_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/dat_mem_stk_stk_ctrl.sv
// Stack controller: entry counter, full/empty, sticky ovf/unf, sp and top addresses.
// Latency: op/sp/top are combinational from cnt; cnt and the flags update on the next clk edge.
// Backpressure: a push when full or a pop when empty is dropped and sets the sticky flag.
module stk_ctrl
    import dat_mem_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int STK_BASE  = 2**AW - 1,
    parameter int STK_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    output stk_op_t       op,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic [AW-1:0] sp,
    output logic [AW-1:0] top
);

    localparam int            CW     = $clog2(STK_DEPTH + 1);
    localparam logic [AW-1:0] BASE_A = AW'(STK_BASE);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    assign full  = (cnt_q == CW'(STK_DEPTH));
    assign empty = (cnt_q == '0);
    assign op    = stk_decode(push, pop, full, empty);

    // The stack grows downward: sp is the next free slot, top sits just above it.
    assign sp  = BASE_A - AW'(cnt_q);
    assign top = sp + AW'(1);

    assign ovf = ovf_q;
    assign unf = unf_q;

    // Next-state for the entry count and the sticky error flags.
    always_comb begin
        cnt_d = cnt_q;
        unique case (op)
            STK_PUSH: cnt_d = cnt_q + CW'(1);
            STK_POP:  cnt_d = cnt_q - CW'(1);
            default:  cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q | (push & ~pop & full);
        unf_d = unf_q | (pop & ~push & empty);
    end

    // Counter and flag registers; flags only clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule

// File: rtl/dat_mem_stk.sv
// Byte data memory with a downward-growing hardware stack at the top of the array.
// Latency: reads are combinational; with DAT_MEM_STK_REG_RD_EN defined, dat_out/pop_dat are registered (1 cycle).
// Backpressure: none; a stack write wins the single write port and a displaced store pulses st_drop.
module dat_mem_stk
    import dat_mem_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int STK_BASE  = 2**AW - 1,
    parameter int STK_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dat_in,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dat_out,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_dat,
    output logic [DW-1:0] pop_dat,
    output logic [AW-1:0] sp,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic          st_drop
);

    localparam int DEPTH = 2**AW;

    stk_op_t       op;
    logic [AW-1:0] top;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    logic          st_drop_q, st_drop_d;
    logic [DW-1:0] rd_dat;
    logic [DW-1:0] top_dat;

    stk_ctrl #(
        .AW        (AW),
        .STK_BASE  (STK_BASE),
        .STK_DEPTH (STK_DEPTH)
    ) u_stk_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .op    (op),
        .full  (full),
        .empty (empty),
        .ovf   (ovf),
        .unf   (unf),
        .sp    (sp),
        .top   (top)
    );

    // Write-port arbitration: an effective push or swap owns the port, otherwise a store may use it.
    always_comb begin
        mem_we    = 1'b0;
        mem_wa    = '0;
        mem_wd    = '0;
        st_drop_d = 1'b0;
        unique case (op)
            STK_PUSH: begin
                mem_we    = 1'b1;
                mem_wa    = sp;
                mem_wd    = push_dat;
                st_drop_d = wr_en;
            end
            STK_SWAP: begin
                mem_we    = 1'b1;
                mem_wa    = top;
                mem_wd    = push_dat;
                st_drop_d = wr_en;
            end
            default: begin
                mem_we = wr_en;
                mem_wa = addr;
                mem_wd = dat_in;
            end
        endcase
    end

    // Array write. Contents survive reset, but nothing commits on an edge taken while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (mem_we) begin
                mem_q[mem_wa] <= mem_wd;
            end
        end
    end

    // One-cycle pulse reporting a store that lost the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_drop_q <= 1'b0;
        end else begin
            st_drop_q <= st_drop_d;
        end
    end

    assign st_drop = st_drop_q;

    assign rd_dat  = mem_q[addr];
    assign top_dat = empty ? '0 : mem_q[top];

`ifdef DAT_MEM_STK_REG_RD_EN
    logic [DW-1:0] dat_out_q;
    logic [DW-1:0] pop_dat_q;

    // Registered reads; top_dat is sampled before cnt moves, so a pop returns the popped entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_out_q <= '0;
            pop_dat_q <= '0;
        end else begin
            dat_out_q <= rd_dat;
            pop_dat_q <= top_dat;
        end
    end

    assign dat_out = dat_out_q;
    assign pop_dat = pop_dat_q;
`else
    assign dat_out = rd_dat;
    assign pop_dat = top_dat;
`endif

endmodule

// File: tb/tb_dat_mem_stk.sv
// Self-checking bench for dat_mem_stk in its default (combinational read) build.
// Latency: inputs change 1 ns after each rising edge; outputs are compared before the next edge.
// Backpressure: not applicable; every cycle is driven and checked.
module tb_dat_mem_stk;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dat_in;
    logic       wr_en;
    logic [7:0] addr;
    logic [7:0] dat_out;
    logic       push;
    logic       pop;
    logic [7:0] push_dat;
    logic [7:0] pop_dat;
    logic [7:0] sp;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       st_drop;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: byte array plus entry count and flags.
    logic [7:0] mm [256];
    int         mc;
    bit         movf, munf, mdrop;

    always #5 clk = ~clk;

    dat_mem_stk dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dat_in   (dat_in),
        .wr_en    (wr_en),
        .addr     (addr),
        .dat_out  (dat_out),
        .push     (push),
        .pop      (pop),
        .push_dat (push_dat),
        .pop_dat  (pop_dat),
        .sp       (sp),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .unf      (unf),
        .st_drop  (st_drop)
    );

    typedef struct {
        logic       push, pop;
        logic [7:0] pd;
        logic       wr;
        logic [7:0] a, din;
        logic [7:0] e_dat, e_pop, e_sp;
        logic       e_empty, e_full, e_ovf, e_unf, e_drop;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic pu, input logic po, input logic [7:0] pd,
                                input logic wr, input logic [7:0] a, input logic [7:0] din,
                                input logic [7:0] edat, input logic [7:0] epop, input logic [7:0] esp,
                                input logic ee, input logic ef, input logic eo,
                                input logic eu, input logic ed);
        vec_t v;
        v.push = pu; v.pop = po; v.pd = pd; v.wr = wr; v.a = a; v.din = din;
        v.e_dat = edat; v.e_pop = epop; v.e_sp = esp;
        v.e_empty = ee; v.e_full = ef; v.e_ovf = eo; v.e_unf = eu; v.e_drop = ed;
        return v;
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; push_dat = 8'h00;
        wr_en = 1'b0; addr = 8'h00; dat_in = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        mc = 0; movf = 1'b0; munf = 1'b0; mdrop = 1'b0;
    endtask

    // Fill the whole array through the store port so later reads are well defined.
    task automatic init_mem(input logic [7:0] key);
        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1; addr = 8'(i); dat_in = 8'(i) ^ key;
            mm[i] = 8'(i) ^ key;
            step();
        end
        idle();
    endtask

    // Compare all outputs against the model, then advance the model by one edge.
    task automatic model_cycle();
        int  t;
        bit  stk_wr;
        t = 255 - mc + 1;
        chk8("rnd_dat_out", dat_out, mm[addr]);
        chk8("rnd_pop_dat", pop_dat, (mc == 0) ? 8'h00 : mm[t & 255]);
        chk8("rnd_sp", sp, 8'((255 - mc) & 255));
        chk1("rnd_full", full, mc == 16);
        chk1("rnd_empty", empty, mc == 0);
        chk1("rnd_ovf", ovf, movf);
        chk1("rnd_unf", unf, munf);
        chk1("rnd_st_drop", st_drop, mdrop);
        stk_wr = 1'b0;
        if (push && pop && mc > 0) begin
            mm[(255 - mc + 1) & 255] = push_dat;
            stk_wr = 1'b1;
        end else if (push && mc < 16) begin
            mm[(255 - mc) & 255] = push_dat;
            mc++;
            stk_wr = 1'b1;
        end else if (push) begin
            movf = 1'b1;
        end else if (pop && mc > 0) begin
            mc--;
        end else if (pop) begin
            munf = 1'b1;
        end
        if (wr_en && !stk_wr) mm[addr] = dat_in;
        mdrop = wr_en && stk_wr;
        step();
    endtask

    initial begin
        idle();
        do_reset();

        // Reset state.
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_full", full, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chk1("rst_unf", unf, 1'b0);
        chk1("rst_st_drop", st_drop, 1'b0);
        chk8("rst_sp", sp, 8'hFF);
        chk8("rst_pop_dat", pop_dat, 8'h00);

        init_mem(8'h00);

        //          pu    po    pd     wr    a      din    dat    pop    sp     e     f     o     u     d
        vt[0]  = mk(1'b1, 1'b0, 8'h11, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b1, 1'b0, 8'h22, 1'b0, 8'hFF, 8'h00, 8'h11, 8'h11, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[2]  = mk(1'b1, 1'b0, 8'h33, 1'b0, 8'hFE, 8'h00, 8'h22, 8'h22, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFD, 8'h00, 8'h33, 8'h33, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[4]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFC, 8'h00, 8'hFC, 8'h22, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h11, 8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h11, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[8]  = mk(1'b1, 1'b0, 8'h22, 1'b1, 8'h3C, 8'h1E, 8'h3C, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vt[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h00, 8'h3C, 8'h22, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b1, 1'b1, 8'h5A, 1'b0, 8'hFF, 8'h00, 8'h22, 8'h22, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h5A, 8'h5A, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 8'h1E, 8'h3C, 8'h5A, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'h00, 8'h1E, 8'h5A, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[14] = mk(1'b1, 1'b0, 8'h77, 1'b1, 8'h3D, 8'h99, 8'h3D, 8'h5A, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vt[15] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h3D, 8'h00, 8'h3D, 8'h77, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[16] = mk(1'b0, 1'b1, 8'h00, 1'b1, 8'h3E, 8'h44, 8'h3E, 8'h77, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[17] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h3E, 8'h00, 8'h44, 8'h5A, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 18; i++) begin
            push = vt[i].push; pop = vt[i].pop; push_dat = vt[i].pd;
            wr_en = vt[i].wr; addr = vt[i].a; dat_in = vt[i].din;
            #1;
            chk8($sformatf("v%0d_dat_out", i), dat_out, vt[i].e_dat);
            chk8($sformatf("v%0d_pop_dat", i), pop_dat, vt[i].e_pop);
            step();
            chk8($sformatf("v%0d_sp", i), sp, vt[i].e_sp);
            chk1($sformatf("v%0d_empty", i), empty, vt[i].e_empty);
            chk1($sformatf("v%0d_full", i), full, vt[i].e_full);
            chk1($sformatf("v%0d_ovf", i), ovf, vt[i].e_ovf);
            chk1($sformatf("v%0d_unf", i), unf, vt[i].e_unf);
            chk1($sformatf("v%0d_st_drop", i), st_drop, vt[i].e_drop);
        end
        idle();

        // Fill to full from one entry, then an overflowing push with a concurrent store.
        for (int i = 0; i < 15; i++) begin
            push = 1'b1; push_dat = 8'(i + 1);
            step();
        end
        idle();
        chk1("fill_full", full, 1'b1);
        chk8("fill_sp", sp, 8'hEF);
        chk1("fill_ovf", ovf, 1'b0);
        push = 1'b1; push_dat = 8'hAA; wr_en = 1'b1; addr = 8'h50; dat_in = 8'h55;
        step();
        idle();
        chk1("ovf_set", ovf, 1'b1);
        chk1("ovf_full", full, 1'b1);
        chk8("ovf_sp", sp, 8'hEF);
        chk1("ovf_no_drop", st_drop, 1'b0);
        chk8("ovf_top", pop_dat, 8'h0F);
        addr = 8'hEF;
        #1;
        chk8("ovf_slot_untouched", dat_out, 8'hEF);
        addr = 8'h50;
        #1;
        chk8("ovf_store_kept", dat_out, 8'h55);
        step();

        // Asynchronous reset while full with ovf set, with a push and store in flight.
        push = 1'b1; push_dat = 8'hBB; wr_en = 1'b1; addr = 8'h46; dat_in = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_empty", empty, 1'b1);
        chk1("arst_full", full, 1'b0);
        chk1("arst_ovf", ovf, 1'b0);
        chk1("arst_unf", unf, 1'b0);
        chk8("arst_sp", sp, 8'hFF);
        step();
        idle();
        rst_n = 1'b1;
        addr = 8'h46;
        #1;
        chk8("arst_store_blocked", dat_out, 8'h46);
        addr = 8'hFF;
        #1;
        chk8("arst_push_blocked", dat_out, 8'h5A);
        mc = 0; movf = 1'b0; munf = 1'b0; mdrop = 1'b0;
        step();

        // Randomised traffic against the model, alternating push-heavy and pop-heavy phases.
        init_mem(8'h5A);
        for (int i = 0; i < 3000; i++) begin
            int  pp;
            bit  heavy;
            heavy = ((i / 200) % 2) == 0;
            pp = heavy ? 65 : 30;
            push     = ($urandom_range(0, 99) < pp);
            pop      = ($urandom_range(0, 99) < (95 - pp));
            push_dat = 8'($urandom);
            wr_en    = ($urandom_range(0, 2) == 0);
            addr     = ($urandom_range(0, 1) == 1) ? 8'(224 + $urandom_range(0, 31)) : 8'($urandom);
            dat_in   = 8'($urandom);
            #1;
            model_cycle();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
